// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared single-port data memory: core (port 0) and DMA/debug (port 1).
// Round-robin on ties, bounded locked bursts, and error pulses for misaligned or out-of-range addresses.
module dmem_arbiter #(
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e        state_q, state_d;
  logic          lastWinner_q, lastWinner_d;
  logic [CW-1:0] burstCnt_q, burstCnt_d;
  logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  logic          grant0, grant1, anyGrant;
  logic [31:0]   selAddr, selWdata;
  logic          selWe, selLock, addrBad, goodAccess;

  // An active owner keeps the memory; otherwise ties go to the port that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (state_q == OWN0 && req0) begin
        grant0 = 1'b1;
      end else if (state_q == OWN1 && req1) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        grant0 = lastWinner_q;
        grant1 = !lastWinner_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign anyGrant   = grant0 | grant1;
  assign selAddr    = grant1 ? addr1  : addr0;
  assign selWdata   = grant1 ? wdata1 : wdata0;
  assign selWe      = grant1 ? we1    : we0;
  assign selLock    = grant1 ? lock1  : lock0;
  assign addrBad    = (selAddr[1:0] != 2'b00) || ({2'b00, selAddr[31:2]} >= 32'(DEPTH));
  assign goodAccess = anyGrant && !addrBad;

  assign gnt0      = grant0;
  assign gnt1      = grant1;
  assign mem_read  = goodAccess && !selWe;
  assign mem_write = goodAccess && selWe;
  assign mem_addr  = goodAccess ? selAddr  : 32'h0;
  assign mem_wdata = goodAccess ? selWdata : 32'h0;

  // Ownership continues only while the winner asks for it and the burst budget is not spent.
  always_comb begin
    state_d      = IDLE;
    burstCnt_d   = '0;
    lastWinner_d = lastWinner_q;
    if (anyGrant) begin
      lastWinner_d = grant1;
      if (selLock && (burstCnt_q < LastBeat)) begin
        state_d    = grant1 ? OWN1 : OWN0;
        burstCnt_d = burstCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lastWinner_q <= 1'b1;
      burstCnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      lastWinner_q <= lastWinner_d;
      burstCnt_q   <= burstCnt_d;
      rvalid0_q    <= grant0 && goodAccess && !we0;
      rvalid1_q    <= grant1 && goodAccess && !we1;
      err0_q       <= grant0 && addrBad;
      err1_q       <= grant1 && addrBad;
      if (grant0 && goodAccess && !we0) begin
        rdata0_q <= mem_rdata;
      end
      if (grant1 && goodAccess && !we1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for bursts, ownership hand-off and reset in the middle of a burst.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        memRead, memWrite;
  logic [31:0] memAddr, memWdata, memRdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  expGm;
    logic [31:0] expAddr, expWdata;
    logic [3:0]  expResp;
    logic [31:0] expRdata0, expRdata1;
  } vec_t;

  vec_t vecs [13];

  dmem_arbiter #(.DEPTH(64), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  assign memRdata = (memAddr < 32'd256) ? mem[memAddr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (memWrite) mem[memAddr[7:2]] <= memWdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    {req0, req1, we0, we1, lock0, lock1} = 6'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {req0, req1, we0, we1, lock0, lock1} = v.ctl;
    addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("v%0d.gnt0", idx),     {31'h0, gnt0},     {31'h0, v.expGm[3]});
    checkVal($sformatf("v%0d.gnt1", idx),     {31'h0, gnt1},     {31'h0, v.expGm[2]});
    checkVal($sformatf("v%0d.memRead", idx),  {31'h0, memRead},  {31'h0, v.expGm[1]});
    checkVal($sformatf("v%0d.memWrite", idx), {31'h0, memWrite}, {31'h0, v.expGm[0]});
    checkVal($sformatf("v%0d.memAddr", idx),  memAddr,  v.expAddr);
    checkVal($sformatf("v%0d.memWdata", idx), memWdata, v.expWdata);
    checkVal($sformatf("v%0d.rvalid0", idx),  {31'h0, rvalid0}, {31'h0, v.expResp[3]});
    checkVal($sformatf("v%0d.rvalid1", idx),  {31'h0, rvalid1}, {31'h0, v.expResp[2]});
    checkVal($sformatf("v%0d.err0", idx),     {31'h0, err0},    {31'h0, v.expResp[1]});
    checkVal($sformatf("v%0d.err1", idx),     {31'h0, err1},    {31'h0, v.expResp[0]});
    checkVal($sformatf("v%0d.rdata0", idx),   rdata0, v.expRdata0);
    checkVal($sformatf("v%0d.rdata1", idx),   rdata1, v.expRdata1);
  endtask

  initial begin
    // ctl = {req0,req1,we0,we1,lock0,lock1}; expGm = {gnt0,gnt1,read,write}; expResp = {rvalid0,rvalid1,err0,err1}
    vecs[0]  = '{6'b110000, 32'h8,   32'hC,  32'h0,        32'h0,        4'b1010, 32'h8,  32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[1]  = '{6'b110000, 32'h8,   32'hC,  32'h0,        32'h0,        4'b0110, 32'hC,  32'h0,        4'b1000, 32'h10000002, 32'h0};
    vecs[2]  = '{6'b101000, 32'h10,  32'h0,  32'hDEADBEEF, 32'h0,        4'b1001, 32'h10, 32'hDEADBEEF, 4'b0100, 32'h10000002, 32'h10000003};
    vecs[3]  = '{6'b100000, 32'h10,  32'h0,  32'h0,        32'h0,        4'b1010, 32'h10, 32'h0,        4'b0000, 32'h10000002, 32'h10000003};
    vecs[4]  = '{6'b000000, 32'h0,   32'h0,  32'h0,        32'h0,        4'b0000, 32'h0,  32'h0,        4'b1000, 32'hDEADBEEF, 32'h10000003};
    vecs[5]  = '{6'b100000, 32'h102, 32'h0,  32'h0,        32'h0,        4'b1000, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'h10000003};
    vecs[6]  = '{6'b100000, 32'h100, 32'h0,  32'h0,        32'h0,        4'b1000, 32'h0,  32'h0,        4'b0010, 32'hDEADBEEF, 32'h10000003};
    vecs[7]  = '{6'b101000, 32'h100, 32'h0,  32'h12345678, 32'h0,        4'b1000, 32'h0,  32'h0,        4'b0010, 32'hDEADBEEF, 32'h10000003};
    vecs[8]  = '{6'b010000, 32'h0,   32'h3,  32'h0,        32'h0,        4'b0100, 32'h0,  32'h0,        4'b0010, 32'hDEADBEEF, 32'h10000003};
    vecs[9]  = '{6'b010100, 32'h0,   32'hFC, 32'h0,        32'hCAFEF00D, 4'b0101, 32'hFC, 32'hCAFEF00D, 4'b0001, 32'hDEADBEEF, 32'h10000003};
    vecs[10] = '{6'b000000, 32'h0,   32'h0,  32'h0,        32'h0,        4'b0000, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'h10000003};
    vecs[11] = '{6'b100000, 32'hFC,  32'h0,  32'h0,        32'h0,        4'b1010, 32'hFC, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h10000003};
    vecs[12] = '{6'b000000, 32'h0,   32'h0,  32'h0,        32'h0,        4'b0000, 32'h0,  32'h0,        4'b1000, 32'hCAFEF00D, 32'h10000003};

    for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 + i;

    // Reset with both ports requesting: nothing may be granted or written.
    rst = 1'b1;
    clearInputs();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checkVal("rst.gnt", {30'h0, gnt0, gnt1}, 32'h0);
      checkVal("rst.memWrite", {31'h0, memWrite}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    clearInputs();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    checkVal("mem[4].afterWrite", mem[4], 32'hDEADBEEF);
    checkVal("mem[63].afterWrite", mem[63], 32'hCAFEF00D);

    // Locked port1 burst against a continuously requesting port0 (port0 won last).
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
      req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1;
      addr1 = 32'(c * 4); wdata1 = 32'hA5000000 + 32'(c);
      #1;
      checkVal($sformatf("burst%0d.gnt1", c), {31'h0, gnt1}, {31'h0, (c < 8)});
      checkVal($sformatf("burst%0d.gnt0", c), {31'h0, gnt0}, {31'h0, (c == 8)});
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkVal("burst.rvalid0", {31'h0, rvalid0}, 32'h1);
    checkVal("burst.rdata0", rdata0, 32'h10000008);
    for (int i = 0; i < 8; i++) checkVal($sformatf("burst.mem[%0d]", i), mem[i], 32'hA5000000 + 32'(i));

    // Port0 takes a lock, blocks port1, then drops req and port1 takes over the same cycle.
    @(negedge clk);
    req0 = 1'b1; lock0 = 1'b1; addr0 = 32'h0;
    #1;
    checkVal("lockA.gnt0", {31'h0, gnt0}, 32'h1);
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'h4;
    #1;
    checkVal("lockB.gnt0", {31'h0, gnt0}, 32'h1);
    checkVal("lockB.gnt1", {31'h0, gnt1}, 32'h0);
    @(negedge clk);
    req0 = 1'b0; lock0 = 1'b0; lock1 = 1'b1;
    #1;
    checkVal("drop.gnt1", {31'h0, gnt1}, 32'h1);
    checkVal("drop.memAddr", memAddr, 32'h4);
    @(negedge clk);
    req0 = 1'b1; lock1 = 1'b0;
    #1;
    checkVal("own1.gnt1", {31'h0, gnt1}, 32'h1);
    checkVal("own1.gnt0", {31'h0, gnt0}, 32'h0);
    @(negedge clk);
    clearInputs();

    // Reset arrives during a locked port1 read burst.
    @(negedge clk);
    req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h8;
    #1;
    checkVal("rb1.gnt1", {31'h0, gnt1}, 32'h1);
    @(negedge clk);
    addr1 = 32'hC;
    #1;
    checkVal("rb2.gnt1", {31'h0, gnt1}, 32'h1);
    @(negedge clk);
    rst = 1'b1; we1 = 1'b1; addr1 = 32'h0; wdata1 = 32'hBAD0BAD0;
    #1;
    checkVal("rstBurst.gnt1", {31'h0, gnt1}, 32'h0);
    checkVal("rstBurst.memWrite", {31'h0, memWrite}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; addr0 = 32'h0; we1 = 1'b0; lock1 = 1'b0; addr1 = 32'h4;
    #1;
    checkVal("postRst.rvalid1", {31'h0, rvalid1}, 32'h0);
    checkVal("postRst.rdata1", rdata1, 32'h0);
    checkVal("postRst.gnt0", {31'h0, gnt0}, 32'h1);
    checkVal("postRst.gnt1", {31'h0, gnt1}, 32'h0);
    checkVal("postRst.mem[0]", mem[0], 32'hA5000000);
    @(negedge clk);
    clearInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port word-addressed data memory between the core load/store port (port 0) and the DMA/debug port (port 1).
- Selects one access per cycle, drives the memory's read/write strobes, address and write data, and registers read data back to the winner.
- Supports round-robin fairness, bounded locked bursts, and address/alignment error reporting.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory; valid word index 0..DEPTH-1.
- MAX_BURST, 8, maximum consecutive locked grants to one port before ownership is forcibly released (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0/req1  in  1  access request, port 0 / port 1
- we0/we1  in  1  1=write, 0=read
- lock0/lock1  in  1  request to keep ownership for the next beat
- addr0/addr1  in  32  byte address
- wdata0/wdata1  in  32  write data
- gnt0/gnt1  out  1  combinational grant; access is consumed this cycle
- rvalid0/rvalid1  out  1  one-cycle pulse, read data valid
- rdata0/rdata1  out  32  registered read data
- err0/err1  out  1  one-cycle pulse, granted access had a bad address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state=IDLE, last_winner=1 (port 0 wins the first tie), burst_cnt=0, rvalid*=0, err*=0, rdata*=0. While rst=1: gnt*=0, mem_read=mem_write=0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: that port holds a lock.
- Arbitration (IDLE, or OWNx with reqx=0):
  - Single requester is granted.
  - If both request, grant the port != last_winner.
  - No requesters: no grant; memory strobes 0.
  - No bubble when an owner drops req; arbitration happens the same cycle.
- OWNx with reqx=1: grant x unconditionally; the other port is blocked.
- On any grant to port p:
  - last_winner<=p.
  - If lockp=1 and burst_cnt+1 < MAX_BURST: next state OWNp, burst_cnt<=burst_cnt+1.
  - Otherwise: next state IDLE, burst_cnt<=0.
- Ownership expiry: after MAX_BURST consecutive grants, the other port wins the next cycle if it requests (last_winner rule).
- Address check:
  - Bad = addr[1:0]!=0, or addr[31:2] >= DEPTH.
  - Bad access: gnt still asserted (request consumed), mem_read=mem_write=0, errp=1 next cycle, no rvalid, memory untouched.
- Memory drive for a good granted access:
  - mem_addr = addrp.
  - mem_wdata = wdatap.
  - mem_write = wep.
  - mem_read = !wep.
- Write latency: the write commits at the grant edge; no response pulse.
- Read latency: 1 cycle. At the grant edge, rdatap<=mem_rdata; rvalidp=1 for exactly the next cycle.
- rdata holds its last value until the next read to that port.
- No grant: mem_addr/mem_wdata=0, strobes 0.
- rvalid/err pulse only for the granted port, never both ports in the same cycle.
- A port may issue back-to-back accesses every cycle; its response pipeline overlaps with the next grant.
- lock from the non-granted port is ignored.
- Reset mid-burst: the owner is dropped, pending rvalid/err are cleared on the reset edge, and no memory write occurs during the rst cycle.

Test Plan:
- Reset, then req0 read addr 0x8 and req1 read addr 0xC in the same cycle -> gnt0=1, gnt1=0; next cycle rvalid0=1 with rdata0=mem[2]. Both still requesting -> gnt1 next (alternation).
- port1 lock1=1, continuous write bursts to 0x0,0x4,...; req0 held high -> gnt1 for exactly MAX_BURST=8 cycles, then gnt0=1 on cycle 9; memory words 0..7 written.
- port0 write 0xDEADBEEF to 0x10, then read 0x10 next cycle -> rvalid0=1, rdata0=0xDEADBEEF two cycles after the write grant.
- port0 read addr 0x102 (misaligned) and addr 0x100 (index 64 >= DEPTH):
  - gnt0=1 each, mem_read=0.
  - err0 pulses next cycle, rvalid0=0.
  - A write to 0x100 leaves memory unchanged.
- Owner port0 locked, drops req0 while req1=1 -> gnt1 in that same cycle, state leaves OWN0.
- Assert rst during port1 locked burst with a read outstanding -> next cycle rvalid1=0, state IDLE; after release, tie goes to port0.
